sram_fifo_ctrl: RTL and testbench

- Upstream controller for the 8-entry single-port `SRAM`; drives its dataIn/Addr/WE/RD and consumes its dataOut.
- Turns the SRAM into a valid/ready FIFO: push side for producers, pop side for consumers.
- Arbitrates the single SRAM port between writes and read-prefetches.
- Hides SRAM read latency behind a small output register buffer.

---
 rtl/sram_pkg.sv | 12 +
 rtl/out_buf.sv | 63 ++++++
 rtl/sram_fifo_ctrl.sv | 100 ++++++++++
 tb/tb_sram_fifo_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared widths, depth and port-ownership encoding for the SRAM-backed FIFO.
package sram_pkg;
   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 2 ** AW;
   localparam int OBUF  = 3;

   typedef enum logic {
      OP_WRITE = 1'b0,
      OP_READ  = 1'b1
   } op_e;
endpackage

// File: rtl/out_buf.sv
// Small shift-register output buffer: captures SRAM read data at the tail,
// presents the head, shifts on pop.
module out_buf
   import sram_pkg::*;
#(
   parameter int W = sram_pkg::DW,
   parameter int N = sram_pkg::OBUF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         capture,
   input  logic [W-1:0] captureData,
   input  logic         pop,
   output logic [1:0]   count,
   output logic [W-1:0] head
);

   logic [N-1:0][W-1:0] bufReg;
   logic [N-1:0][W-1:0] bufNext;
   logic [1:0]          cntReg;
   logic [1:0]          cntNext;
   logic [1:0]          wrIdx;

   // A same-cycle pop frees the slot below the current tail.
   assign wrIdx = pop ? (cntReg - 2'd1) : cntReg;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_entry
         logic [W-1:0] shiftIn;
         if (gi == N - 1) begin : g_last
            assign shiftIn = '0;
         end else begin : g_mid
            assign shiftIn = bufReg[gi+1];
         end
         assign bufNext[gi] = (capture && wrIdx == 2'(gi)) ? captureData :
                              (pop ? shiftIn : bufReg[gi]);
      end
   endgenerate

   always_comb begin
      cntNext = cntReg;
      if (capture && !pop) begin
         cntNext = cntReg + 2'd1;
      end else if (pop && !capture) begin
         cntNext = cntReg - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bufReg <= '0;
         cntReg <= '0;
      end else begin
         bufReg <= bufNext;
         cntReg <= cntNext;
      end
   end

   assign count = cntReg;
   assign head  = bufReg[0];

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO built on a single-port SRAM; arbitrates the port between
// pushes and read-prefetches that keep the output buffer topped up.
module sram_fifo_ctrl
   import sram_pkg::*;
#(
   parameter int DW   = sram_pkg::DW,
   parameter int AW   = sram_pkg::AW,
   parameter int OBUF = sram_pkg::OBUF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [3:0]    level,
   output logic [DW-1:0] sram_din,
   output logic [AW-1:0] sram_addr,
   output logic          sram_we,
   output logic          sram_rd,
   input  logic [DW-1:0] sram_dout
);

   localparam logic [AW:0] FULL_CNT = (AW + 1)'(2 ** AW);

   logic [AW-1:0] wrPtrReg, wrPtrNext;
   logic [AW-1:0] rdPtrReg, rdPtrNext;
   logic [AW:0]   cntReg, cntNext;
   logic          inflightReg, inflightNext;
   op_e           lastOpReg, lastOpNext;

   logic       rdReq, wrSlot, wrIssue, rdIssue, popEn;
   logic [1:0] bufCnt;

   // Prefetch only while the buffer still has room once in-flight data lands.
   assign rdReq   = (cntReg != '0) && (({1'b0, bufCnt} + {2'b0, inflightReg}) <= 3'd2);
   assign wrSlot  = (cntReg != FULL_CNT) && (!rdReq || lastOpReg == OP_READ);
   assign in_ready = wrSlot && !rst;
   assign wrIssue = in_valid && in_ready;
   assign rdIssue = rdReq && !wrIssue;

   assign sram_we   = wrIssue;
   assign sram_rd   = rdIssue;
   assign sram_addr = wrIssue ? wrPtrReg : rdPtrReg;
   assign sram_din  = wrIssue ? in_data : '0;

   always_comb begin
      wrPtrNext    = wrPtrReg;
      rdPtrNext    = rdPtrReg;
      cntNext      = cntReg;
      lastOpNext   = lastOpReg;
      inflightNext = rdIssue;
      if (wrIssue) begin
         wrPtrNext  = wrPtrReg + AW'(1);
         cntNext    = cntReg + (AW + 1)'(1);
         lastOpNext = OP_WRITE;
      end else if (rdIssue) begin
         rdPtrNext  = rdPtrReg + AW'(1);
         cntNext    = cntReg - (AW + 1)'(1);
         lastOpNext = OP_READ;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtrReg    <= '0;
         rdPtrReg    <= '0;
         cntReg      <= '0;
         inflightReg <= 1'b0;
         lastOpReg   <= OP_WRITE;
      end else begin
         wrPtrReg    <= wrPtrNext;
         rdPtrReg    <= rdPtrNext;
         cntReg      <= cntNext;
         inflightReg <= inflightNext;
         lastOpReg   <= lastOpNext;
      end
   end

   assign popEn     = out_valid && out_ready;
   assign out_valid = (bufCnt != 2'd0);

   out_buf #(
      .W (DW),
      .N (OBUF)
   ) u_out_buf (
      .clk         (clk),
      .rst         (rst),
      .capture     (inflightReg),
      .captureData (sram_dout),
      .pop         (popEn),
      .count       (bufCnt),
      .head        (out_data)
   );

   assign level = 4'(cntReg) + 4'(bufCnt) + 4'(inflightReg);

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl with a behavioural SRAM; checks FIFO order, level
// and port usage against a queue-based reference model.
module tb_sram_fifo_ctrl;
   import sram_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [3:0]    level;
   logic [DW-1:0] sram_din;
   logic [AW-1:0] sram_addr;
   logic          sram_we;
   logic          sram_rd;
   logic [DW-1:0] sram_dout;

   sram_fifo_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level),
      .sram_din  (sram_din),
      .sram_addr (sram_addr),
      .sram_we   (sram_we),
      .sram_rd   (sram_rd),
      .sram_dout (sram_dout)
   );

   always #5 clk = ~clk;

   // Behavioural single-port SRAM: registered read data held until next edge.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      if (sram_rd) sram_dout <= mem[sram_addr];
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: ordered contents of the whole FIFO plus SRAM port issue counts.
   logic [DW-1:0] q[$];
   int wrCnt = 0;
   int rdCnt = 0;
   bit monOn = 0;
   bit streamMode = 0;
   bit prevWe = 0;

   always @(negedge clk) begin
      if (monOn) begin
         chk("we_rd_excl", sram_we && sram_rd, 0);
         chk("level", level, q.size());
         if (streamMode) chk("we_b2b", sram_we && prevWe, 0);
         if ((wrCnt - rdCnt) == DEPTH) chk("full_block", in_ready, 0);
         if (sram_we) begin
            chk("wr_addr", sram_addr, wrCnt % DEPTH);
            chk("wr_din", sram_din, in_data);
            wrCnt++;
         end
         if (sram_rd) begin
            chk("rd_addr", sram_addr, rdCnt % DEPTH);
            chk("rd_nonempty", wrCnt > rdCnt, 1);
            rdCnt++;
         end
         if (in_valid && in_ready) begin
            q.push_back(in_data);
            $display("push %02h level=%0d", in_data, level);
         end
         if (out_valid && out_ready) begin
            chk("pop_avail", q.size() > 0, 1);
            if (q.size() > 0) chk("pop_data", out_data, q.pop_front());
            $display("pop  %02h level=%0d", out_data, level);
         end
         prevWe = sram_we;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic modelClear();
      q.delete();
      wrCnt  = 0;
      rdCnt  = 0;
      prevWe = 0;
   endtask

   task automatic pushWord(input logic [DW-1:0] d);
      bit accepted;
      accepted = 0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 60 && !accepted; i++) begin
         @(negedge clk);
         accepted = in_ready;
         tick();
      end
      in_valid = 1'b0;
      chk("push_timeout", accepted, 1);
   endtask

   task automatic popN(input int n);
      int got;
      got = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 100 && got < n; i++) begin
         @(negedge clk);
         if (out_valid) got++;
         tick();
      end
      out_ready = 1'b0;
      chk("popn_count", got, n);
   endtask

   task automatic drain();
      bit done;
      done = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = (level == 4'd0);
         tick();
      end
      out_ready = 1'b0;
      chk("drain_level", level, 0);
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      int t0;
      bit seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_we", sram_we, 0);
      chk("rst_rd", sram_rd, 0);
      chk("rst_out_data", out_data, 0);
      @(negedge clk);
      tick();
      rst = 1'b0;
      modelClear();
      monOn = 1;
      @(negedge clk);
      chk("ready_after_rst", in_ready, 1);
      tick();

      // Single push latency
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hA5;
      @(negedge clk);
      chk("single_we", sram_we, 1);
      chk("single_wr_addr", sram_addr, 0);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("single_rd", sram_rd, 1);
      chk("single_rd_addr", sram_addr, 0);
      tick();
      @(negedge clk);
      chk("single_early", out_valid, 0);
      tick();
      @(negedge clk);
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 8'hA5);
      tick();
      @(negedge clk);
      chk("single_level", level, 0);
      tick();
      out_ready = 1'b0;

      // Fill to capacity
      for (int d = 1; d <= 11; d++) pushWord(8'(d));
      repeat (4) tick();
      @(negedge clk);
      chk("fill_level", level, 11);
      chk("fill_ready", in_ready, 0);
      tick();
      in_valid = 1'b1;
      in_data  = 8'h0C;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("fill_held_off", in_ready, 0);
         tick();
      end
      in_valid = 1'b0;
      drain();

      // Pointer wrap with partial drain
      for (int d = 8'h10; d <= 8'h17; d++) pushWord(8'(d));
      popN(4);
      for (int d = 8'h20; d <= 8'h23; d++) pushWord(8'(d));
      drain();

      // Concurrent push/pop streams
      streamMode = 1;
      t0 = cyc;
      fork
         begin
            for (int i = 0; i < 20; i++) pushWord(8'($urandom));
         end
         popN(20);
      join
      streamMode = 0;
      chk("stream_rate", (cyc - t0) <= 50, 1);
      drain();

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid = 1'b0;
      drain();

      // Asynchronous reset while a read is in flight
      in_valid = 1'b1;
      in_data  = 8'h77;
      tick();
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      chk("pre_rst_level", level, 1);
      tick();
      in_valid = 1'b1;
      in_data  = 8'h78;
      tick();
      in_valid = 1'b0;
      tick();
      #2;
      monOn = 0;
      rst   = 1'b1;
      #1;
      chk("arst_in_ready", in_ready, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_level", level, 0);
      chk("arst_we", sram_we, 0);
      chk("arst_rd", sram_rd, 0);
      chk("arst_addr", sram_addr, 0);
      chk("arst_din", sram_din, 0);
      chk("arst_out_data", out_data, 0);
      tick();
      tick();
      rst = 1'b0;
      modelClear();
      monOn = 1;
      pushWord(8'h3C);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
         if (!seen) tick();
      end
      chk("post_rst_valid", seen, 1);
      chk("post_rst_first", out_data, 8'h3C);
      tick();
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
